// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-through, write-no-allocate data cache
// One word per line; misses and stores go to memory over a req/ack handshake.
module dcache_dm #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SETS       = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            byte_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                state, next_state;
  logic [SETS-1:0]       valid;
  logic [TAG_W-1:0]      tag_arr  [SETS];
  logic [DATA_WIDTH-1:0] data_arr [SETS];
  logic                  after_fill;

  logic [IDX_W-1:0] idx, lat_idx;
  logic [TAG_W-1:0] tag, lat_tag;
  logic             hit, lat_hit;
  logic             unused_low;

  assign idx        = addr[IDX_W+1:2];
  assign tag        = addr[ADDR_WIDTH-1:IDX_W+2];
  assign lat_idx    = mem_addr[IDX_W+1:2];
  assign lat_tag    = mem_addr[ADDR_WIDTH-1:IDX_W+2];
  assign hit        = valid[idx] && (tag_arr[idx] == tag);
  assign lat_hit    = valid[lat_idx] && (tag_arr[lat_idx] == lat_tag);
  assign unused_low = &{1'b0, addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (wr_en) next_state = WRITE;
               else if (rd_en && !hit) next_state = FILL;
      FILL:    if (mem_ack) next_state = IDLE;
      WRITE:   if (mem_ack) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    rdata = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (wr_en) stall = 1'b1;
          else if (rd_en) begin
            if (hit) rdata = data_arr[idx];
            else     stall = 1'b1;
          end
        end
        FILL, WRITE: stall = 1'b1;
        default:     stall = 1'b0;
      endcase
    end
  end

  // The re-lookup right after a fill is the same load retiring; it was already counted as a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      after_fill <= 1'b0;
    end else begin
      after_fill <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= wdata;
            mem_be    <= byte_en;
            mem_we    <= 1'b1;
            mem_req   <= 1'b1;
          end else if (rd_en) begin
            if (hit) begin
              if (!after_fill) hit_cnt <= hit_cnt + 32'd1;
            end else begin
              mem_addr <= {addr[ADDR_WIDTH-1:2], 2'b00};
              mem_we   <= 1'b0;
              mem_req  <= 1'b1;
              miss_cnt <= miss_cnt + 32'd1;
            end
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid[lat_idx] <= 1'b1;
            mem_req        <= 1'b0;
            after_fill     <= 1'b1;
          end
        end
        WRITE: begin
          if (mem_ack) mem_req <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tag/data storage needs no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == FILL && mem_ack) begin
        tag_arr[lat_idx]  <= lat_tag;
        data_arr[lat_idx] <= mem_rdata;
      end else if (state == WRITE && mem_ack && lat_hit) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) data_arr[lat_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - randomized self-checking bench for dcache_dm
// Memory responder plus a set-level reference of which lines the cache should hold.
module tb_dcache_dm;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  byte_en = '0;
  logic [31:0] rdata;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;
  logic [31:0] hit_cnt, miss_cnt;

  dcache_dm dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wdata(wdata), .byte_en(byte_en), .rdata(rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [int unsigned];

  function automatic logic [31:0] get_word(input logic [31:0] w);
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference: which tag each set should hold, and expected counters.
  bit          m_valid [256];
  logic [21:0] m_tag   [256];
  int unsigned m_hits = 0, m_miss = 0;

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[9:2]] && (m_tag[a[9:2]] == a[31:10]);
  endfunction

  int   ack_delay = 0;
  bit   resp_en = 1'b1;
  logic resp_ack = 1'b0, manual_ack = 1'b0;
  int   wait_cnt = 0;
  assign mem_ack = resp_ack | manual_ack;

  initial forever begin
    @(negedge clk);
    resp_ack = 1'b0;
    if (mem_req && resp_en) begin
      if (wait_cnt >= ack_delay) begin
        logic [31:0] w;
        resp_ack = 1'b1;
        wait_cnt = 0;
        w = get_word(mem_addr >> 2);
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          mem[mem_addr >> 2] = w;
        end else begin
          mem_rdata = w;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  logic [31:0] last_rdata;

  task automatic do_load(input logic [31:0] a, input int d, input string tag);
    bit h;
    int n;
    h = m_hit(a);
    ack_delay = d;
    @(negedge clk);
    addr = a; rd_en = 1'b1; wr_en = 1'b0;
    #1;
    n = 0;
    while (stall && n < 50) begin
      n++;
      @(negedge clk); #1;
    end
    last_rdata = rdata;
    check({tag, " rdata"}, rdata, get_word(a >> 2));
    check({tag, " stall_cycles"}, n, h ? 0 : d + 2);
    check({tag, " mem_req"}, {31'd0, mem_req}, 32'd0);
    if (h) m_hits++;
    else begin
      m_miss++;
      m_valid[a[9:2]] = 1'b1;
      m_tag[a[9:2]]   = a[31:10];
    end
    @(posedge clk); #1;
    rd_en = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input bit also_rd, input int d, input string tag);
    int n;
    ack_delay = d;
    @(negedge clk);
    addr = a; wdata = wd; byte_en = be; wr_en = 1'b1; rd_en = also_rd;
    #1;
    n = 0;
    while (stall && n < 50) begin
      n++;
      @(negedge clk); #1;
    end
    check({tag, " stall_cycles"}, n, d + 2);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check({tag, " mem_req_after"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset hit_cnt", hit_cnt, 32'd0);
    check("reset miss_cnt", miss_cnt, 32'd0);

    mem[32'h100 >> 2] = 32'h1122_3344;
    do_load(32'h100, 3, "cold");
    check("cold word", last_rdata, 32'h1122_3344);
    check("cold miss_cnt", miss_cnt, 32'd1);
    do_load(32'h100, 2, "warm");
    check("warm hit_cnt", hit_cnt, 32'd1);

    do_store(32'h100, 32'h0000_AB00, 4'b0010, 1'b0, 1, "st_hit");
    do_load(32'h100, 1, "st_reload");
    check("merged word", last_rdata, 32'h1122_AB44);

    do_store(32'h200, 32'hCAFE_F00D, 4'b1111, 1'b0, 0, "st_miss");
    do_load(32'h200, 2, "noalloc");
    check("noalloc word", last_rdata, 32'hCAFE_F00D);

    do_load(32'h100 + 4 * 256, 1, "alias");
    do_load(32'h100, 0, "evicted");
    check("dir hit_cnt", hit_cnt, m_hits);
    check("dir miss_cnt", miss_cnt, m_miss);

    // Reset in the middle of a fill, then a stray ack
    resp_en = 1'b0;
    @(negedge clk);
    addr = 32'h300; rd_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("fill mem_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1; rd_en = 1'b0;
    #1;
    check("rst stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst miss_cnt", miss_cnt, 32'd0);
    mem_rdata = 32'hDEAD_BEEF;
    manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    #1;
    check("stray ack mem_req", {31'd0, mem_req}, 32'd0);
    check("stray ack stall", {31'd0, stall}, 32'd0);
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_hits = 0; m_miss = 0;
    resp_en = 1'b1;
    do_load(32'h300, 1, "post_rst_a");
    do_load(32'h100, 2, "post_rst_b");

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int d;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0)
        do_store(a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), d, "rnd_st");
      else
        do_load(a, d, "rnd_ld");
    end
    check("final hit_cnt", hit_cnt, m_hits);
    check("final miss_cnt", miss_cnt, m_miss);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
